mem_ctrl: RTL and testbench

//  Responder side of the CPU memory interface: serves 32-bit instruction-fetch requests from inst_fetch and

---
 rtl/mem_ctrl_pkg.sv | 36 +++
 rtl/mem_ctrl_if.sv | 49 ++++
 rtl/mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory controller slice: FSM state encodings,
// access-length encodings (bytes-1) and a helper that folds the illegal
// length code into a full word.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    // Access length, stored as "number of bytes minus one"
    typedef logic [1:0] len_t;

    localparam len_t LEN_B = 2'd0;
    localparam len_t LEN_H = 2'd1;
    localparam len_t LEN_W = 2'd3;

    // Controller states: idle, instruction-fetch read, load read, store write
    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_IF_RD = 2'd1,
        MC_LS_RD = 2'd2,
        MC_LS_WR = 2'd3
    } mcState_t;

    // The unused code 2 behaves like a word access so a bad request can never
    // leave the byte counter without a terminating count.
    function automatic len_t normLen(input len_t len);
        len_t result;
        case (len)
            LEN_B:   result = LEN_B;
            LEN_H:   result = LEN_H;
            default: result = LEN_W;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the fetch port, the load/store port and the byte-wide RAM bus seen
// by mem_ctrl.
//   master : requesters plus RAM (drive requests and mem_din)
//   slave  : mem_ctrl (answers requests, drives the RAM address/data/write)
// Fetch   : if_valid, if_addr, if_clear -> if_done, if_data
// LdSt    : ls_valid, ls_wr, ls_len, ls_addr, ls_wdata -> ls_done, ls_rdata
// RAM bus : mem_din -> mem_dout, mem_a, mem_wr
// -----------------------------------------------------------------------------
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_clear;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_valid;
    logic        ls_wr;
    len_t        ls_len;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        output if_valid, if_addr, if_clear,
        output ls_valid, ls_wr, ls_len, ls_addr, ls_wdata,
        output mem_din,
        input  if_done, if_data, ls_done, ls_rdata,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_valid, if_addr, if_clear,
        input  ls_valid, ls_wr, ls_len, ls_addr, ls_wdata,
        input  mem_din,
        output if_done, if_data, ls_done, ls_rdata,
        output mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Responder for the CPU memory port. Serves 32-bit fetches and byte/half/word
// loads and stores over a single byte-wide RAM bus, one byte per cycle,
// assembling little-endian words and pulsing a one-cycle done.
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-low reset
//   rdy_in  - low freezes every register and masks mem_wr
//   bus     - mem_ctrl_if.slave (fetch port, load/store port, RAM bus)
// Parameter:
//   LS_PRIORITY - 1: load/store wins a same-cycle tie, 0: fetch wins
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LS_PRIORITY = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    mem_ctrl_if.slave  bus
);

    mcState_t    r_state;
    mcState_t    w_nextState;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    len_t        r_len;
    logic [31:0] r_wdata;
    logic [31:0] r_asm;
    logic [31:0] r_ifData;
    logic [31:0] r_lsRdata;

    logic        w_pickIf;
    logic        w_pickLs;
    logic [2:0]  w_lenP1;
    logic [2:0]  w_lenP2;
    logic        w_reading;
    logic        w_issue;
    logic        w_capture;
    logic        w_lastCapture;
    logic        w_memWrQ;
    logic [7:0]  w_wrByte;
    logic [31:0] w_asmNext;

    // Arbitration between the two requesters. Only meaningful in IDLE; a
    // fetch is never taken in a cycle where it is being cleared.
    always_comb begin
        w_pickIf = 1'b0;
        w_pickLs = 1'b0;
        if (r_state == MC_IDLE) begin
            if (LS_PRIORITY != 0) begin
                w_pickLs = bus.ls_valid;
                w_pickIf = !bus.ls_valid && bus.if_valid && !bus.if_clear;
            end else begin
                w_pickIf = bus.if_valid && !bus.if_clear;
                w_pickLs = !w_pickIf && bus.ls_valid;
            end
        end
    end

    // Counter landmarks. r_cnt = k while byte k's address is on the bus, so
    // the last write is at cnt == len, a store completes at len+1, and a
    // read (one extra cycle of RAM latency) completes at len+2.
    assign w_lenP1       = {1'b0, r_len} + 3'd1;
    assign w_lenP2       = {1'b0, r_len} + 3'd2;
    assign w_reading     = (r_state == MC_IF_RD) || (r_state == MC_LS_RD);
    assign w_issue       = (r_state != MC_IDLE) && (r_cnt <= {1'b0, r_len});
    assign w_capture     = w_reading && (r_cnt != 3'd0) && (r_cnt <= w_lenP1);
    assign w_lastCapture = w_reading && (r_cnt == w_lenP1);

    // Next-state and done logic. Done is qualified by rdy_in so a stall in
    // the completion cycle still yields exactly one active pulse.
    always_comb begin
        w_nextState = r_state;
        bus.if_done = 1'b0;
        bus.ls_done = 1'b0;
        case (r_state)
            MC_IDLE: begin
                if (w_pickLs) begin
                    w_nextState = bus.ls_wr ? MC_LS_WR : MC_LS_RD;
                end else if (w_pickIf) begin
                    w_nextState = MC_IF_RD;
                end
            end
            MC_IF_RD: begin
                if (bus.if_clear) begin
                    w_nextState = MC_IDLE;
                end else if (r_cnt == w_lenP2) begin
                    w_nextState = MC_IDLE;
                    bus.if_done = rdy_in;
                end
            end
            MC_LS_RD: begin
                if (r_cnt == w_lenP2) begin
                    w_nextState = MC_IDLE;
                    bus.ls_done = rdy_in;
                end
            end
            MC_LS_WR: begin
                if (r_cnt == w_lenP1) begin
                    w_nextState = MC_IDLE;
                    bus.ls_done = rdy_in;
                end
            end
            default: w_nextState = MC_IDLE;
        endcase
    end

    // RAM bus drive. The address and write byte come straight from the
    // counter so they line up with the cycle the counter names.
    always_comb begin
        bus.mem_a    = '0;
        bus.mem_dout = '0;
        w_memWrQ     = 1'b0;
        case (r_cnt)
            3'd0:    w_wrByte = r_wdata[7:0];
            3'd1:    w_wrByte = r_wdata[15:8];
            3'd2:    w_wrByte = r_wdata[23:16];
            3'd3:    w_wrByte = r_wdata[31:24];
            default: w_wrByte = 8'h00;
        endcase
        if (w_issue) begin
            bus.mem_a = r_addr + {29'd0, r_cnt};
            if (r_state == MC_LS_WR) begin
                bus.mem_dout = w_wrByte;
                w_memWrQ     = 1'b1;
            end
        end
    end

    // A frozen cycle must not repeat a write, so the strobe is masked by rdy_in.
    assign bus.mem_wr = w_memWrQ & rdy_in;

    // Lane insert for read data: mem_din arriving at cnt = k+1 is byte k.
    always_comb begin
        w_asmNext = r_asm;
        case (r_cnt)
            3'd1:    w_asmNext[7:0]   = bus.mem_din;
            3'd2:    w_asmNext[15:8]  = bus.mem_din;
            3'd3:    w_asmNext[23:16] = bus.mem_din;
            3'd4:    w_asmNext[31:24] = bus.mem_din;
            default: w_asmNext = r_asm;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= MC_IDLE;
        end else if (rdy_in) begin
            r_state <= w_nextState;
        end
    end

    // Datapath: latch the request on acceptance, then step the byte counter
    // and build the word. The result registers only change on the final byte
    // so a cleared fetch leaves if_data alone, and the assembly register is
    // zeroed on acceptance so short loads come out zero-extended.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_len     <= LEN_B;
            r_wdata   <= '0;
            r_asm     <= '0;
            r_ifData  <= '0;
            r_lsRdata <= '0;
        end else if (rdy_in) begin
            if (r_state == MC_IDLE) begin
                r_cnt <= '0;
                r_asm <= '0;
                if (w_pickLs) begin
                    r_addr  <= bus.ls_addr;
                    r_len   <= normLen(bus.ls_len);
                    r_wdata <= bus.ls_wdata;
                end else if (w_pickIf) begin
                    r_addr <= bus.if_addr;
                    r_len  <= LEN_W;
                end
            end else begin
                r_cnt <= r_cnt + 3'd1;
                if (w_capture) begin
                    r_asm <= w_asmNext;
                end
                if (w_lastCapture) begin
                    if (r_state == MC_IF_RD && !bus.if_clear) begin
                        r_ifData <= w_asmNext;
                    end
                    if (r_state == MC_LS_RD) begin
                        r_lsRdata <= w_asmNext;
                    end
                end
            end
        end
    end

    assign bus.if_data  = r_ifData;
    assign bus.ls_rdata = r_lsRdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. A byte RAM with one cycle of read latency
// answers the bus; a sparse reference memory predicts every load/fetch result
// and every completion latency from the request alone.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    mem_ctrl_if bus();

    mem_ctrl #(.LS_PRIORITY(1)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    // 10 ns clock
    always #5 clk_in = ~clk_in;

    logic [7:0]  ram [0:262143];
    int          wrCount [0:262143];
    logic        preWe   = 1'b0;
    logic [17:0] preAddr = '0;
    logic [7:0]  preData = '0;
    logic [7:0]  refMem [int];
    int          total = 0;
    int          bad   = 0;

    // RAM: only address bits 17:0 decode; read data appears the cycle after
    // its address. Preload writes come from the bench through preWe.
    always @(posedge clk_in) begin
        if (preWe) begin
            ram[preAddr] <= preData;
        end else if (bus.mem_wr) begin
            ram[bus.mem_a[17:0]]     <= bus.mem_dout;
            wrCount[bus.mem_a[17:0]] <= wrCount[bus.mem_a[17:0]] + 1;
        end
        bus.mem_din <= ram[bus.mem_a[17:0]];
    end

    function automatic int refKey(input logic [31:0] a);
        return int'({14'd0, a[17:0]});
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        if (refMem.exists(refKey(a))) return refMem[refKey(a)];
        return 8'h00;
    endfunction

    // Little-endian read of effLen+1 bytes, upper bytes zero.
    function automatic logic [31:0] refRead(input logic [31:0] a, input int effLen);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (k <= effLen) r[8*k +: 8] = refByte(a + 32'(k));
        end
        return r;
    endfunction

    task automatic preloadByte(input logic [31:0] a, input logic [7:0] v);
        preWe   = 1'b1;
        preAddr = a[17:0];
        preData = v;
        refMem[refKey(a)] = v;
        @(posedge clk_in);
        #1;
        preWe = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request (kind 0 fetch, 1 load, 2 store) and follow it to its
    // done pulse. Every cycle where rdy_in is high and a byte is still due,
    // mem_a must be addr+beat and mem_wr must match the direction; outside
    // those beats mem_wr must be low. Optional 3-cycle rdy stall from stallAt.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] len,
                                 input logic [31:0] wdata, input int stallAt,
                                 output logic [31:0] data, output int lat, output int busErr);
        int n;
        int beat;
        int effLen;
        bit done;
        effLen = (kind == 0) ? 3 : ((len == 2'd2) ? 3 : int'(len));
        n = 0; beat = 0; done = 1'b0; lat = -1; busErr = 0; data = '0;
        if (kind == 0) begin
            bus.if_valid = 1'b1;
            bus.if_addr  = addr;
        end else begin
            bus.ls_valid = 1'b1;
            bus.ls_wr    = (kind == 2);
            bus.ls_len   = len;
            bus.ls_addr  = addr;
            bus.ls_wdata = wdata;
        end
        while (!done && n < 60) begin
            @(posedge clk_in);
            #1;
            n++;
            if (rdy_in === 1'b1 && beat <= effLen) begin
                if (bus.mem_a !== addr + 32'(beat) || bus.mem_wr !== (kind == 2)) busErr++;
                beat++;
            end else if (bus.mem_wr !== 1'b0) begin
                busErr++;
            end
            if (bus.if_done === 1'b1 && bus.ls_done === 1'b1) busErr++;
            if (kind == 0 && bus.if_done === 1'b1) begin
                done = 1'b1; lat = n; data = bus.if_data;
            end else if (kind != 0 && bus.ls_done === 1'b1) begin
                done = 1'b1; lat = n; data = bus.ls_rdata;
            end
            if (kind == 0 && bus.ls_done !== 1'b0) busErr++;
            if (kind != 0 && bus.if_done !== 1'b0) busErr++;
            if (stallAt > 0 && n == stallAt) rdy_in = 1'b0;
            if (stallAt > 0 && n == stallAt + 3) rdy_in = 1'b1;
        end
        bus.if_valid = 1'b0;
        bus.ls_valid = 1'b0;
        rdy_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp;
        logic [31:0] hold;
        logic [31:0] idleA;
        logic [31:0] lsData;
        int lat;
        int err;
        int n;
        int lsAt;
        int ifAt;
        int kind;
        int effLen;
        logic [1:0] len;
        logic [31:0] addr;
        logic [31:0] wdata;
        int w0 [4];
        int cnt;

        bus.if_valid = 1'b0; bus.if_addr = '0; bus.if_clear = 1'b0;
        bus.ls_valid = 1'b0; bus.ls_wr = 1'b0; bus.ls_len = LEN_B;
        bus.ls_addr = '0; bus.ls_wdata = '0;

        // Reset held while the RAM is preloaded
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("reset mem_a", bus.mem_a, 32'h0);
        checkOutput("reset mem_wr", {31'd0, bus.mem_wr}, 32'h0);
        checkOutput("reset dones", {30'd0, bus.if_done, bus.ls_done}, 32'h0);
        checkOutput("reset if_data", bus.if_data, 32'h0);
        checkOutput("reset ls_rdata", bus.ls_rdata, 32'h0);

        preloadByte(32'h100, 8'h13); preloadByte(32'h101, 8'h05);
        preloadByte(32'h102, 8'h00); preloadByte(32'h103, 8'h00);
        preloadByte(32'h2000, 8'h11); preloadByte(32'h2001, 8'h22);
        preloadByte(32'h2002, 8'h33); preloadByte(32'h2003, 8'h44);
        preloadByte(32'h80, 8'hA5);
        preloadByte(32'h84, 8'hDE); preloadByte(32'h85, 8'hAD);
        preloadByte(32'h86, 8'hBE); preloadByte(32'h87, 8'hEF);
        preloadByte(32'h3100, 8'h55); preloadByte(32'h3101, 8'h66);
        preloadByte(32'h3102, 8'h77); preloadByte(32'h3103, 8'h88);
        preloadByte(32'h3FFFE, 8'h9A); preloadByte(32'h3FFFF, 8'hBC);
        preloadByte(32'h0, 8'hDE); preloadByte(32'h1, 8'hF0);
        for (int i = 0; i < 64; i++) preloadByte(32'h3000 + 32'(i), 8'($urandom));
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        $display("[TB] word fetch from 0x100");
        applyStimulus(0, 32'h100, 2'd3, '0, 0, d, lat, err);
        checkOutput("fetch latency", 32'(lat), 32'd6);
        checkOutput("fetch bus", 32'(err), 32'd0);
        checkOutput("fetch data", d, 32'h00000513);

        $display("[TB] half store to 0x2001");
        applyStimulus(2, 32'h2001, 2'd1, 32'hABCD1234, 0, d, lat, err);
        checkOutput("half store latency", 32'(lat), 32'd3);
        checkOutput("half store bus", 32'(err), 32'd0);
        checkOutput("half store ram", {ram[18'h2003], ram[18'h2002], ram[18'h2001], ram[18'h2000]}, 32'h44123411);
        refMem[refKey(32'h2001)] = 8'h34;
        refMem[refKey(32'h2002)] = 8'h12;

        $display("[TB] simultaneous fetch and byte load");
        bus.if_valid = 1'b1; bus.if_addr = 32'h84;
        bus.ls_valid = 1'b1; bus.ls_wr = 1'b0; bus.ls_len = LEN_B; bus.ls_addr = 32'h80;
        n = 0; lsAt = -1; ifAt = -1; lsData = '0; d = '0;
        while (n < 30 && ifAt < 0) begin
            @(posedge clk_in);
            #1;
            n++;
            if (bus.ls_done === 1'b1) begin lsAt = n; lsData = bus.ls_rdata; bus.ls_valid = 1'b0; end
            if (bus.if_done === 1'b1) begin ifAt = n; d = bus.if_data; bus.if_valid = 1'b0; end
        end
        bus.if_valid = 1'b0; bus.ls_valid = 1'b0;
        @(posedge clk_in);
        #1;
        checkOutput("tie ls_done time", 32'(lsAt), 32'd3);
        checkOutput("tie ls_rdata", lsData, 32'h000000A5);
        checkOutput("tie if_done time", 32'(ifAt), 32'd10);
        checkOutput("tie if_data", d, refRead(32'h84, 3));

        $display("[TB] fetch aborted by if_clear");
        bus.if_valid = 1'b1; bus.if_addr = 32'h3000;
        n = 0; ifAt = -1; hold = '0; idleA = 32'hFFFFFFFF; d = '0;
        while (n < 30 && ifAt < 0) begin
            @(posedge clk_in);
            #1;
            n++;
            if (bus.if_done === 1'b1) begin ifAt = n; d = bus.if_data; bus.if_valid = 1'b0; end
            if (n == 4) idleA = bus.mem_a;
            if (n == 9) hold = bus.if_data;
            if (n == 3) bus.if_clear = 1'b1;
            if (n == 4) begin bus.if_clear = 1'b0; bus.if_addr = 32'h100; end
        end
        bus.if_valid = 1'b0; bus.if_clear = 1'b0;
        @(posedge clk_in);
        #1;
        checkOutput("clear idle mem_a", idleA, 32'h0);
        checkOutput("clear if_data held", hold, refRead(32'h84, 3));
        checkOutput("clear refetch time", 32'(ifAt), 32'd10);
        checkOutput("clear refetch data", d, 32'h00000513);

        $display("[TB] word store with 3-cycle stall");
        for (int k = 0; k < 4; k++) w0[k] = wrCount[18'h3200 + 18'(k)];
        applyStimulus(2, 32'h3200, 2'd3, 32'hCAFEF00D, 2, d, lat, err);
        cnt = 0;
        for (int k = 0; k < 4; k++) if (wrCount[18'h3200 + 18'(k)] - w0[k] != 1) cnt++;
        checkOutput("stall latency", 32'(lat), 32'd8);
        checkOutput("stall bus", 32'(err), 32'd0);
        checkOutput("stall writes once", 32'(cnt), 32'd0);
        checkOutput("stall ram", {ram[18'h3203], ram[18'h3202], ram[18'h3201], ram[18'h3200]}, 32'hCAFEF00D);
        for (int k = 0; k < 4; k++) refMem[refKey(32'h3200 + 32'(k))] = ram[18'h3200 + 18'(k)];

        $display("[TB] reset during word store");
        w0[2] = wrCount[18'h3102]; w0[3] = wrCount[18'h3103];
        bus.ls_valid = 1'b1; bus.ls_wr = 1'b1; bus.ls_len = LEN_W;
        bus.ls_addr = 32'h3100; bus.ls_wdata = 32'h01020304;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b0; bus.ls_valid = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        checkOutput("post-reset bus", {bus.mem_a[23:0], bus.mem_dout}, 32'h0);
        checkOutput("post-reset strobes", {29'd0, bus.mem_wr, bus.if_done, bus.ls_done}, 32'h0);
        checkOutput("post-reset data", bus.if_data | bus.ls_rdata, 32'h0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_in);
            #1;
            if (bus.ls_done !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_wr !== 1'b0) cnt++;
        end
        checkOutput("post-reset silent", 32'(cnt), 32'd0);
        checkOutput("post-reset bytes kept", {16'd0, ram[18'h3103], ram[18'h3102]}, 32'h00008877);
        checkOutput("post-reset no writes", 32'((wrCount[18'h3102] - w0[2]) + (wrCount[18'h3103] - w0[3])), 32'd0);
        applyStimulus(0, 32'hFFFFFFFE, 2'd3, '0, 0, d, lat, err);
        checkOutput("wrap fetch latency", 32'(lat), 32'd6);
        checkOutput("wrap fetch bus", 32'(err), 32'd0);
        checkOutput("wrap fetch data", d, 32'h F0DEBC9A);

        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            kind   = int'($urandom_range(0, 2));
            len    = (kind == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            addr   = 32'h3000 + 32'($urandom_range(0, 60));
            wdata  = $urandom;
            effLen = (len == 2'd2) ? 3 : int'(len);
            exp    = refRead(addr, effLen);
            applyStimulus(kind, addr, len, wdata, 0, d, lat, err);
            checkOutput("rnd latency", 32'(lat), 32'((kind == 2) ? effLen + 2 : effLen + 3));
            checkOutput("rnd bus", 32'(err), 32'd0);
            if (kind != 2) begin
                checkOutput("rnd data", d, exp);
            end else begin
                for (int k = 0; k <= effLen; k++) refMem[refKey(addr + 32'(k))] = wdata[8*k +: 8];
            end
        end
        cnt = 0;
        for (int i = 0; i < 64; i++) if (ram[18'h3000 + 18'(i)] !== refByte(32'h3000 + 32'(i))) cnt++;
        checkOutput("rnd ram image", 32'(cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
